dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single 128-bit-line data memory between the instruction cache (read-only line fills) and the data cache (line fills and write-through line stores). It owns the memory's CSN/WEN/address/data pins and sequences each access: grant, one-cycle chip select, fixed-latency wait, one-cycle acknowledge. It sits between the cache controllers and the data memory; its BUSY output feeds the pipeline stall logic.

## Interface
- MEM_LATENCY, 6, cycles from the CSN-low cycle to the cycle in which MEM_DI is valid; legal range 1..15.
- CLK  in  1  clock; all state changes on posedge.
- RSTn  in  1  reset, synchronous, active-low.
- I_REQ  in  1  I-cache read request; held with I_ADDR until I_ACK.
- I_ADDR  in  10  I-cache line address.
- I_RDATA  out  128  line returned to I-cache; valid while I_ACK=1, then held.
- I_ACK  out  1  one-cycle completion pulse to I-cache.
- D_REQ  in  1  D-cache request; held with D_WE/D_ADDR/D_WDATA until D_ACK.
- D_WE  in  1  1 = line write, 0 = line read.
- D_ADDR  in  10  D-cache line address.
- D_WDATA  in  128  line to write.
- D_RDATA  out  128  line returned to D-cache (reads only); valid while D_ACK=1, then held.
- D_ACK  out  1  one-cycle completion pulse to D-cache.
- MEM_CSN  out  1  memory chip select, active-low.
- MEM_WEN  out  1  memory write enable, active-low.
- MEM_ADDR  out  10  memory line address.
- MEM_DOUT  out  128  line written to memory.
- MEM_DI  in  128  line read from memory.
- BUSY  out  1  high while a transaction is in flight.
- OWNER  out  1  current/last grant: 0 = I-cache, 1 = D-cache.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any REQ is sampled high, latch the winner's address/WE/WDATA into MEM_ADDR/MEM_DOUT and its WE, set OWNER, go to ISSUE. Otherwise stay.
- ISSUE (one cycle): MEM_CSN=0; MEM_WEN=0 iff the winner is D with D_WE=1, else 1. Load counter with MEM_LATENCY-1; go to WAIT.
- WAIT: MEM_CSN=1, MEM_WEN=1; counter decrements each cycle; when it reaches 0, capture MEM_DI into the owner's RDATA (reads only) and go to DONE.
- DONE (one cycle): owner's ACK=1; go to IDLE.
- Arbitration on a simultaneous request: D-cache wins (see Configuration). The loser keeps REQ high and is granted in the next IDLE cycle.
- A REQ dropped mid-transaction is ignored: the access completes and ACK still pulses. Changes to the latched address or data after the grant have no effect.
- Writes: RDATA is not updated; ACK timing is identical to reads.
- Counter: 4 bits, no wrap. With MEM_LATENCY=1, WAIT lasts exactly one cycle.
- Reset, including mid-transaction: state IDLE, MEM_CSN=1, MEM_WEN=1, MEM_ADDR=0, MEM_DOUT=0, I_RDATA=0, D_RDATA=0, I_ACK=0, D_ACK=0, BUSY=0, OWNER=0, counter=0. The in-flight access is abandoned and no ACK is issued.

## Timing
- Request first sampled in IDLE at cycle 0: ISSUE at cycle 1, WAIT from cycle 2 to 1+MEM_LATENCY, MEM_DI captured at the end of cycle 1+MEM_LATENCY, ACK in cycle MEM_LATENCY+2. Default: ACK at cycle 8.
- BUSY=1 in ISSUE, WAIT and DONE.
- Requester deasserts REQ on the edge after it sees ACK. The arbiter samples IDLE one cycle after DONE, so back-to-back transactions are MEM_LATENCY+3 cycles apart.
- MEM_CSN is low for exactly one cycle per transaction.
- All outputs are registered.

## Configuration
- ARB_ROUND_ROBIN_EN defined: ties go to the requester not granted last, using a last-grant register that resets to I, so the first tie goes to D. Single requests are granted regardless of history.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, D always wins a tie; I-cache can starve under continuous D_REQ.

## Test plan
- I-cache read alone, I_ADDR=0x155, memory returns 0xA5…A5: MEM_CSN low in cycle 1 only with MEM_WEN=1 and MEM_ADDR=0x155; I_ACK pulses in cycle 8; I_RDATA=0xA5…A5; BUSY high in cycles 1–8.
- D-cache write, D_ADDR=0x3FF, D_WDATA=0x1234…: cycle 1 MEM_CSN=0, MEM_WEN=0, MEM_DOUT=D_WDATA; D_ACK in cycle 8; D_RDATA unchanged.
- I_REQ and D_REQ both high in cycle 0: D served first (D_ACK in cycle 8), then I (MEM_CSN low in cycle 10, I_ACK in cycle 17). Repeat the tie: with ARB_ROUND_ROBIN_EN, I wins the second tie; without it, D wins again.
- RSTn low in cycle 4 of a D read: next cycle IDLE, BUSY=0, MEM_CSN=1, no D_ACK ever; a new request after reset completes normally.
- MEM_LATENCY=1: read ACK in cycle 3 with data captured from cycle 2. MEM_LATENCY=15: ACK in cycle 17.
- D_REQ dropped in cycle 3 and D_ADDR changed in cycle 2: access still completes at the originally latched address, and D_ACK pulses in cycle 8.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares one 128-bit-line data memory between I-cache fills and D-cache fills/stores; ARB_ROUND_ROBIN_EN selects round-robin tie-break.
// Latency: ACK MEM_LATENCY+2 cycles after the request is sampled in IDLE; MEM_CSN low for exactly one cycle per access.
// Backpressure: requesters hold REQ until ACK; the losing requester waits and is granted in the next IDLE cycle.
module dmem_arbiter #(
    parameter int MEM_LATENCY = 6
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         I_REQ,
    input  logic [9:0]   I_ADDR,
    output logic [127:0] I_RDATA,
    output logic         I_ACK,
    input  logic         D_REQ,
    input  logic         D_WE,
    input  logic [9:0]   D_ADDR,
    input  logic [127:0] D_WDATA,
    output logic [127:0] D_RDATA,
    output logic         D_ACK,
    output logic         MEM_CSN,
    output logic         MEM_WEN,
    output logic [9:0]   MEM_ADDR,
    output logic [127:0] MEM_DOUT,
    input  logic [127:0] MEM_DI,
    output logic         BUSY,
    output logic         OWNER
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       we_lat;
    logic       d_win;

`ifdef ARB_ROUND_ROBIN_EN
    // Records only the winner of the last tie, so an uncontested grant never shifts the balance.
    logic rr_last;
    assign d_win = D_REQ && (!I_REQ || !rr_last);
`else
    assign d_win = D_REQ;
`endif

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            we_lat   <= 1'b0;
            MEM_CSN  <= 1'b1;
            MEM_WEN  <= 1'b1;
            MEM_ADDR <= '0;
            MEM_DOUT <= '0;
            I_RDATA  <= '0;
            D_RDATA  <= '0;
            I_ACK    <= 1'b0;
            D_ACK    <= 1'b0;
            BUSY     <= 1'b0;
            OWNER    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (I_REQ || D_REQ) begin
                        state   <= ISSUE;
                        BUSY    <= 1'b1;
                        MEM_CSN <= 1'b0;
                        OWNER   <= d_win;
                        if (d_win) begin
                            MEM_ADDR <= D_ADDR;
                            MEM_DOUT <= D_WDATA;
                            we_lat   <= D_WE;
                            MEM_WEN  <= !D_WE;
                        end else begin
                            MEM_ADDR <= I_ADDR;
                            we_lat   <= 1'b0;
                            MEM_WEN  <= 1'b1;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        if (I_REQ && D_REQ) begin
                            rr_last <= d_win;
                        end
`endif
                    end
                end
                ISSUE: begin
                    MEM_CSN <= 1'b1;
                    MEM_WEN <= 1'b1;
                    cnt     <= CNT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        if (OWNER) begin
                            D_ACK <= 1'b1;
                            if (!we_lat) begin
                                D_RDATA <= MEM_DI;
                            end
                        end else begin
                            I_ACK   <= 1'b1;
                            I_RDATA <= MEM_DI;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    I_ACK <= 1'b0;
                    D_ACK <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed timing sequences plus random traffic against a transaction-level scoreboard.
module tb_dmem_arbiter;

    localparam int LAT = 6;

    typedef struct packed {
        logic         we;
        logic [9:0]   addr;
        logic [127:0] wdata;
    } req_t;

    logic         CLK = 1'b0;
    logic         RSTn;
    logic         I_REQ, D_REQ, D_WE;
    logic [9:0]   I_ADDR, D_ADDR;
    logic [127:0] D_WDATA;
    logic [127:0] MEM_DI;
    logic [127:0] I_RDATA, D_RDATA, MEM_DOUT;
    logic         I_ACK, D_ACK, MEM_CSN, MEM_WEN, BUSY, OWNER;
    logic [9:0]   MEM_ADDR;

    // Second and third instances exercise the latency extremes against a cycle-stamped data pattern.
    logic         aux_req;
    logic [9:0]   aux_addr;
    logic [127:0] aux_di;
    logic [127:0] a1_irdata, a1_drdata, a1_dout, a15_irdata, a15_drdata, a15_dout;
    logic         a1_iack, a1_dack, a1_csn, a1_wen, a1_busy, a1_owner;
    logic         a15_iack, a15_dack, a15_csn, a15_wen, a15_busy, a15_owner;
    logic [9:0]   a1_addr, a15_addr;

    logic [31:0]  cyc = '0;
    int           n_tests = 0;
    int           n_fail = 0;

    req_t         iq[$];
    req_t         dq[$];
    logic [127:0] ref_mem [1024];
    bit           ref_vld [1024];
    logic [127:0] wr_mem  [1024];
    bit           wr_vld  [1024];
    logic [31:0]  rd_due = '1;
    logic [9:0]   rd_addr = '0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    dmem_arbiter #(.MEM_LATENCY(LAT)) u_dut (
        .CLK(CLK), .RSTn(RSTn),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_RDATA(D_RDATA), .D_ACK(D_ACK),
        .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR),
        .MEM_DOUT(MEM_DOUT), .MEM_DI(MEM_DI), .BUSY(BUSY), .OWNER(OWNER)
    );

    dmem_arbiter #(.MEM_LATENCY(1)) u_lat1 (
        .CLK(CLK), .RSTn(RSTn),
        .I_REQ(aux_req), .I_ADDR(aux_addr), .I_RDATA(a1_irdata), .I_ACK(a1_iack),
        .D_REQ(1'b0), .D_WE(1'b0), .D_ADDR(10'd0), .D_WDATA(128'd0),
        .D_RDATA(a1_drdata), .D_ACK(a1_dack),
        .MEM_CSN(a1_csn), .MEM_WEN(a1_wen), .MEM_ADDR(a1_addr),
        .MEM_DOUT(a1_dout), .MEM_DI(aux_di), .BUSY(a1_busy), .OWNER(a1_owner)
    );

    dmem_arbiter #(.MEM_LATENCY(15)) u_lat15 (
        .CLK(CLK), .RSTn(RSTn),
        .I_REQ(aux_req), .I_ADDR(aux_addr), .I_RDATA(a15_irdata), .I_ACK(a15_iack),
        .D_REQ(1'b0), .D_WE(1'b0), .D_ADDR(10'd0), .D_WDATA(128'd0),
        .D_RDATA(a15_drdata), .D_ACK(a15_dack),
        .MEM_CSN(a15_csn), .MEM_WEN(a15_wen), .MEM_ADDR(a15_addr),
        .MEM_DOUT(a15_dout), .MEM_DI(aux_di), .BUSY(a15_busy), .OWNER(a15_owner)
    );

    function automatic logic [127:0] init_line(input logic [9:0] a);
        if (a == 10'h155) return {16{8'hA5}};
        return {4{{22'h15A5A5, a}}};
    endfunction

    function automatic logic [127:0] pat(input logic [31:0] c);
        return {96'hC0FFEE000000000000000000, c};
    endfunction

    function automatic logic [127:0] ref_line(input logic [9:0] a);
        return ref_vld[a] ? ref_mem[a] : init_line(a);
    endfunction

    assign aux_di = pat(cyc);

    // Memory device: data for a read is valid only in the cycle exactly LAT after chip select.
    always @(posedge CLK) begin
        if (!MEM_CSN && !MEM_WEN) begin
            wr_mem[MEM_ADDR] <= MEM_DOUT;
            wr_vld[MEM_ADDR] <= 1'b1;
        end
        if (!MEM_CSN && MEM_WEN) begin
            rd_due  <= cyc + LAT;
            rd_addr <= MEM_ADDR;
        end
        if (rd_due == cyc + 1)
            MEM_DI <= wr_vld[rd_addr] ? wr_mem[rd_addr] : init_line(rd_addr);
        else
            MEM_DI <= {4{32'hDEAD0000 ^ (cyc + 1)}};
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        bit           outst;
        logic [31:0]  csn_cyc;
        logic         csn_own, prev_i, prev_d;
        logic [127:0] exp_i, exp_d;
        req_t         r;
        outst = 0; csn_cyc = '0; csn_own = 0; prev_i = 0; prev_d = 0;
        exp_i = '0; exp_d = '0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                iq.delete(); dq.delete();
                outst = 0; prev_i = 0; prev_d = 0; exp_i = '0; exp_d = '0;
            end else begin
                if (!MEM_CSN) begin
                    check("csn_once", outst, 0);
                    outst = 1; csn_cyc = cyc; csn_own = OWNER;
                    if (OWNER) begin
                        check("d_q_at_issue", dq.size() != 0, 1);
                        if (dq.size() != 0) begin
                            check("d_issue_addr", MEM_ADDR, dq[0].addr);
                            check("d_issue_wen", MEM_WEN, !dq[0].we);
                            if (dq[0].we) check("d_issue_dout", MEM_DOUT, dq[0].wdata);
                        end
                    end else begin
                        check("i_q_at_issue", iq.size() != 0, 1);
                        if (iq.size() != 0) check("i_issue_addr", MEM_ADDR, iq[0].addr);
                        check("i_issue_wen", MEM_WEN, 1);
                    end
                end
                if (I_ACK) begin
                    check("i_ack_pulse", prev_i, 0);
                    check("i_ack_owner", {outst, csn_own}, 2'b10);
                    check("i_ack_lat", cyc - csn_cyc, LAT + 1);
                    check("i_q_at_ack", iq.size() != 0, 1);
                    if (iq.size() != 0) begin
                        r = iq.pop_front();
                        check("i_hold_addr", MEM_ADDR, r.addr);
                        exp_i = ref_line(r.addr);
                    end
                    outst = 0;
                end
                if (D_ACK) begin
                    check("d_ack_pulse", prev_d, 0);
                    check("d_ack_owner", {outst, csn_own}, 2'b11);
                    check("d_ack_lat", cyc - csn_cyc, LAT + 1);
                    check("d_q_at_ack", dq.size() != 0, 1);
                    if (dq.size() != 0) begin
                        r = dq.pop_front();
                        check("d_hold_addr", MEM_ADDR, r.addr);
                        if (r.we) begin
                            ref_mem[r.addr] = r.wdata;
                            ref_vld[r.addr] = 1'b1;
                        end else begin
                            exp_d = ref_line(r.addr);
                        end
                    end
                    outst = 0;
                end
                check("i_rdata", I_RDATA, exp_i);
                check("d_rdata", D_RDATA, exp_d);
                prev_i = I_ACK; prev_d = D_ACK;
            end
        end
    endtask

    task automatic single(input bit is_d, input bit we, input logic [9:0] addr,
                          input logic [127:0] wd, input int chg_k, input int drop_k);
        req_t         r;
        logic [127:0] d_before;
        logic         ack;
        r.we = we; r.addr = addr; r.wdata = wd;
        d_before = D_RDATA;
        if (is_d) begin
            D_REQ = 1; D_WE = we; D_ADDR = addr; D_WDATA = wd; dq.push_back(r);
        end else begin
            I_REQ = 1; I_ADDR = addr; iq.push_back(r);
        end
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge CLK);
            if (k == chg_k) begin D_ADDR = ~addr; D_WDATA = ~wd; end
            if (k == drop_k) D_REQ = 0;
            ack = is_d ? D_ACK : I_ACK;
            check($sformatf("seq csn/busy/ack k=%0d", k), {!MEM_CSN, BUSY, ack},
                  {k == 1, k <= LAT + 2, k == LAT + 2});
            if (k == 1) begin
                check("issue_wen", MEM_WEN, !(is_d && we));
                check("issue_addr", MEM_ADDR, addr);
                if (is_d && we) check("issue_dout", MEM_DOUT, wd);
            end
            if (ack) begin
                if (is_d) D_REQ = 0;
                else I_REQ = 0;
            end
        end
        if (is_d && we) check("d_rdata_unchanged", D_RDATA, d_before);
    endtask

    task automatic tie(input bit d_first);
        req_t ri, rd;
        ri.we = 0; ri.addr = 10'h011; ri.wdata = '0;
        rd.we = 0; rd.addr = 10'h022; rd.wdata = '0;
        I_REQ = 1; I_ADDR = ri.addr; iq.push_back(ri);
        D_REQ = 1; D_WE = 0; D_ADDR = rd.addr; dq.push_back(rd);
        for (int k = 1; k <= 18; k++) begin
            @(negedge CLK);
            check($sformatf("tie csn/iack/dack k=%0d", k), {!MEM_CSN, I_ACK, D_ACK},
                  {(k == 1 || k == 10), k == (d_first ? 17 : 8), k == (d_first ? 8 : 17)});
            if (k == 1) check("tie owner first", OWNER, d_first);
            if (k == 10) check("tie owner second", OWNER, !d_first);
            if (I_ACK) I_REQ = 0;
            if (D_ACK) D_REQ = 0;
        end
    endtask

    initial begin
        req_t        r;
        logic [31:0] c0;
        int          acks;
        RSTn = 0; I_REQ = 0; I_ADDR = '0; D_REQ = 0; D_WE = 0; D_ADDR = '0; D_WDATA = '0;
        aux_req = 0; aux_addr = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge CLK);
        check("rst MEM_CSN", MEM_CSN, 1);
        check("rst MEM_WEN", MEM_WEN, 1);
        check("rst MEM_ADDR", MEM_ADDR, 0);
        check("rst MEM_DOUT", MEM_DOUT, 0);
        check("rst I_RDATA", I_RDATA, 0);
        check("rst D_RDATA", D_RDATA, 0);
        check("rst acks", {I_ACK, D_ACK}, 0);
        check("rst BUSY", BUSY, 0);
        check("rst OWNER", OWNER, 0);
        RSTn = 1;
        @(negedge CLK);

        tie(1);
`ifdef ARB_ROUND_ROBIN_EN
        tie(0);
`else
        tie(1);
`endif

        single(0, 0, 10'h155, '0, 0, 0);
        check("i_rdata_a5", I_RDATA, {16{8'hA5}});
        single(1, 1, 10'h3FF, 128'h123456789ABCDEF0_0FEDCBA987654321, 0, 0);
        single(1, 0, 10'h3FF, '0, 0, 0);
        check("d_readback", D_RDATA, 128'h123456789ABCDEF0_0FEDCBA987654321);

        // Reset in the middle of a D read: access abandoned, no ACK ever.
        r.we = 0; r.addr = 10'h0AA; r.wdata = '0;
        D_REQ = 1; D_WE = 0; D_ADDR = r.addr; dq.push_back(r);
        repeat (4) @(negedge CLK);
        RSTn = 0; D_REQ = 0;
        @(negedge CLK);
        check("midrst BUSY", BUSY, 0);
        check("midrst MEM_CSN/WEN", {MEM_CSN, MEM_WEN}, 2'b11);
        check("midrst MEM_ADDR", MEM_ADDR, 0);
        check("midrst D_RDATA", D_RDATA, 0);
        check("midrst OWNER/ACK", {OWNER, D_ACK}, 0);
        @(negedge CLK);
        RSTn = 1;
        acks = 0;
        repeat (15) begin
            @(negedge CLK);
            acks += int'(D_ACK);
        end
        check("no_ack_after_reset", acks, 0);
        single(1, 0, 10'h0AA, '0, 0, 0);

        single(1, 0, 10'h2C3, '0, 2, 3);

        c0 = cyc;
        aux_req = 1; aux_addr = 10'h0F0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge CLK);
            check($sformatf("lat csn1/csn15/ack1/ack15 k=%0d", k), {!a1_csn, !a15_csn, a1_iack, a15_iack},
                  {k == 1, k == 1, k == 3, k == 17});
            if (k == 3) begin
                check("lat1 data", a1_irdata, pat(c0 + 2));
                aux_req = 0;
            end
            if (k == 17) check("lat15 data", a15_irdata, pat(c0 + 16));
        end

        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            if (I_REQ) begin
                if (I_ACK) I_REQ = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                r.we = 0; r.addr = 10'($urandom_range(0, 15)); r.wdata = '0;
                I_ADDR = r.addr; I_REQ = 1; iq.push_back(r);
            end
            if (D_REQ) begin
                if (D_ACK) D_REQ = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                r.we = 1'($urandom_range(0, 1)); r.addr = 10'($urandom_range(0, 15));
                r.wdata = {$urandom, $urandom, $urandom, $urandom};
                D_WE = r.we; D_ADDR = r.addr; D_WDATA = r.wdata; D_REQ = 1; dq.push_back(r);
            end
        end
        for (int n = 0; n < 40 && (I_REQ || D_REQ); n++) begin
            @(negedge CLK);
            if (I_ACK) I_REQ = 0;
            if (D_ACK) D_REQ = 0;
        end
        check("drain", {I_REQ, D_REQ}, 0);
        repeat (2) @(negedge CLK);
        check("queues_empty", iq.size() + dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
